// File: rtl/timer_ctrl_bank.sv
// Register bank for NUM_CH timer channels: TCR control, TIS sticky status (W1C), TIE enables (TIMER_CTRL_BANK_TIE_EN).
// Latency: reads return 1 cycle after i_rden, writes take effect on the next edge, o_irq is combinational from registers.
// Backpressure: none; every strobe is accepted and every read is answered on the following cycle.
module timer_ctrl_bank #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    localparam int AW        = $clog2(NUM_CH) + 2
) (
    input  logic                         i_clk_sys,
    input  logic                         i_rst,
    input  logic                         i_wren,
    input  logic                         i_rden,
    input  logic [AW-1:0]                i_addr,
    input  logic [DATA_WIDTH-1:0]        i_datain,
    output logic [DATA_WIDTH-1:0]        o_dataout,
    output logic                         o_rvalid,
    input  logic [NUM_CH-1:0]            i_ovf,
    input  logic [NUM_CH-1:0]            i_udf,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_tcr,
    output logic [NUM_CH-1:0]            o_load,
    output logic [NUM_CH-1:0]            o_irq,
    output logic                         o_irq_any
);

    localparam logic [1:0] REG_TCR = 2'd0;
    localparam logic [1:0] REG_TIS = 2'd1;
    localparam logic [1:0] REG_TIE = 2'd2;

    logic [AW-1:0]           ch_idx;
    logic [1:0]              reg_sel;
    logic                    ch_ok;
    logic [2*NUM_CH-1:0]     tis_flat;
    logic [DATA_WIDTH-1:0]   rd_mux;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    rvalid_q;
`ifdef TIMER_CTRL_BANK_TIE_EN
    logic [2*NUM_CH-1:0]     tie_flat;
`endif

    assign ch_idx  = i_addr >> 2;
    assign reg_sel = i_addr[1:0];
    assign ch_ok   = (ch_idx < AW'(NUM_CH));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                  sel;
        logic                  wr_tcr;
        logic                  wr_tis;
        logic                  os_hit;
        logic [DATA_WIDTH-1:0] tcr_q;
        logic [1:0]            tis_q;
        logic                  load_q;

        assign sel    = ch_ok && (ch_idx == AW'(c));
        assign wr_tcr = i_wren && sel && (reg_sel == REG_TCR);
        assign wr_tis = i_wren && sel && (reg_sel == REG_TIS);
        // One-shot stop watches the terminal event matching the count direction.
        assign os_hit = tcr_q[2] && (tcr_q[1] ? i_udf[c] : i_ovf[c]);

        always_ff @(posedge i_clk_sys) begin
            if (i_rst) begin
                tcr_q  <= '0;
                tis_q  <= '0;
                load_q <= 1'b0;
            end else begin
                if (wr_tcr) begin
                    tcr_q <= {i_datain[DATA_WIDTH-1:4], 1'b0, i_datain[2:0]};
                end else if (os_hit) begin
                    tcr_q[0] <= 1'b0;
                end
                // Hardware set is OR-ed in after the clear so it wins a collision.
                tis_q  <= (tis_q & ~(wr_tis ? i_datain[1:0] : 2'b00)) | {i_udf[c], i_ovf[c]};
                load_q <= wr_tcr & i_datain[3];
            end
        end

        assign o_tcr[c*DATA_WIDTH +: DATA_WIDTH] = tcr_q;
        assign tis_flat[2*c +: 2]                = tis_q;
        assign o_load[c]                         = load_q;

`ifdef TIMER_CTRL_BANK_TIE_EN
        logic       wr_tie;
        logic [1:0] tie_q;

        assign wr_tie = i_wren && sel && (reg_sel == REG_TIE);

        always_ff @(posedge i_clk_sys) begin
            if (i_rst) begin
                tie_q <= '0;
            end else if (wr_tie) begin
                tie_q <= i_datain[1:0];
            end
        end

        assign tie_flat[2*c +: 2] = tie_q;
        assign o_irq[c]           = |(tis_q & tie_q);
`else
        assign o_irq[c] = |tis_q;
`endif
    end

    assign o_irq_any = |o_irq;

    // Read mux sees register state before this cycle's write, giving pre-write read data.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_ok && (ch_idx == AW'(c))) begin
                case (reg_sel)
                    REG_TCR: rd_mux = o_tcr[c*DATA_WIDTH +: DATA_WIDTH];
                    REG_TIS: rd_mux = DATA_WIDTH'(tis_flat[2*c +: 2]);
`ifdef TIMER_CTRL_BANK_TIE_EN
                    REG_TIE: rd_mux = DATA_WIDTH'(tie_flat[2*c +: 2]);
`endif
                    default: rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            rvalid_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            rvalid_q <= i_rden;
            if (i_rden) begin
                dout_q <= rd_mux;
            end
        end
    end

    // A read landing while reset is asserted is abandoned, not reported.
    assign o_rvalid  = rvalid_q & ~i_rst;
    assign o_dataout = dout_q;

endmodule

// File: tb/tb_timer_ctrl_bank.sv
// Directed bench for timer_ctrl_bank: read scoreboard queue plus immediate-assertion checks on outputs.
module tb_timer_ctrl_bank;

    localparam int NUM_CH = 4;
    localparam int DW     = 8;

    logic                 i_clk_sys = 1'b0;
    logic                 i_rst     = 1'b1;
    logic                 i_wren    = 1'b0;
    logic                 i_rden    = 1'b0;
    logic [3:0]           i_addr    = '0;
    logic [DW-1:0]        i_datain  = '0;
    logic [DW-1:0]        o_dataout;
    logic                 o_rvalid;
    logic [NUM_CH-1:0]    i_ovf     = '0;
    logic [NUM_CH-1:0]    i_udf     = '0;
    logic [NUM_CH*DW-1:0] o_tcr;
    logic [NUM_CH-1:0]    o_load;
    logic [NUM_CH-1:0]    o_irq;
    logic                 o_irq_any;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] last_rd = '0;

    always #5 i_clk_sys = ~i_clk_sys;

    timer_ctrl_bank #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW)) dut (
        .i_clk_sys (i_clk_sys),
        .i_rst     (i_rst),
        .i_wren    (i_wren),
        .i_rden    (i_rden),
        .i_addr    (i_addr),
        .i_datain  (i_datain),
        .o_dataout (o_dataout),
        .o_rvalid  (o_rvalid),
        .i_ovf     (i_ovf),
        .i_udf     (i_udf),
        .o_tcr     (o_tcr),
        .o_load    (o_load),
        .o_irq     (o_irq),
        .o_irq_any (o_irq_any)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk_sys);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [DW-1:0] d);
        i_wren   = 1'b1;
        i_addr   = a;
        i_datain = d;
        tick();
        i_wren   = 1'b0;
        i_datain = '0;
    endtask

    // Data must arrive exactly one cycle after the strobe; anything later counts as a miss.
    task automatic collect(input string tag);
        logic [DW-1:0] e;
        chk({tag, "_rvalid"}, {31'd0, o_rvalid}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(tag, {24'd0, o_dataout}, {24'd0, e});
            last_rd = e;
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [DW-1:0] exp, input string tag);
        i_rden = 1'b1;
        i_addr = a;
        sb.push_back(exp);
        tick();
        i_rden = 1'b0;
        collect(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_rvalid",  {31'd0, o_rvalid},  32'd0);
        chk("rst_dataout", {24'd0, o_dataout}, 32'd0);
        chk("rst_tcr",     o_tcr,              32'd0);
        chk("rst_load",    {28'd0, o_load},    32'd0);
        chk("rst_irq",     {28'd0, o_irq},     32'd0);
        chk("rst_irq_any", {31'd0, o_irq_any}, 32'd0);
        i_rst = 1'b0;
        tick();

        rd(4'h0, 8'h00, "rd_ch0_tcr");
        tick();
        chk("hold_rvalid",  {31'd0, o_rvalid},  32'd0);
        chk("hold_dataout", {24'd0, o_dataout}, {24'd0, last_rd});

        wr(4'h4, 8'h0F);
        chk("ch1_tcr",       {24'd0, o_tcr[15:8]}, 32'h07);
        chk("ch1_load_hi",   {28'd0, o_load},      32'h2);
        tick();
        chk("ch1_load_lo",   {28'd0, o_load},      32'h0);
        rd(4'h4, 8'h07, "rd_ch1_tcr");

        wr(4'h8, 8'h05);
        wr(4'hA, 8'h01);
        i_ovf = 4'b0100;
        tick();
        i_ovf = '0;
        chk("ch2_oneshot_en", {24'd0, o_tcr[23:16]}, 32'h04);
        chk("ch2_irq",        {28'd0, o_irq},        32'h4);
        chk("ch2_irq_any",    {31'd0, o_irq_any},    32'd1);
        rd(4'h9, 8'h01, "rd_ch2_tis");
`ifdef TIMER_CTRL_BANK_TIE_EN
        rd(4'hA, 8'h01, "rd_ch2_tie");
`else
        rd(4'hA, 8'h00, "rd_ch2_tie_absent");
`endif

        i_wren   = 1'b1;
        i_addr   = 4'h9;
        i_datain = 8'h01;
        i_ovf    = 4'b0100;
        tick();
        i_wren   = 1'b0;
        i_datain = '0;
        i_ovf    = '0;
        rd(4'h9, 8'h01, "rd_ch2_tis_setwins");
        wr(4'h9, 8'h01);
        chk("ch2_irq_cleared", {28'd0, o_irq},     32'h0);
        chk("irq_any_cleared", {31'd0, o_irq_any}, 32'd0);
        rd(4'h9, 8'h00, "rd_ch2_tis_w1c");

        wr(4'hC, 8'h07);
        chk("ch3_tcr", {24'd0, o_tcr[31:24]}, 32'h07);
        i_wren   = 1'b1;
        i_addr   = 4'hC;
        i_datain = 8'h05;
        i_udf    = 4'b1000;
        tick();
        i_wren   = 1'b0;
        i_datain = '0;
        i_udf    = '0;
        chk("ch3_sw_override", {24'd0, o_tcr[31:24]}, 32'h05);
        i_udf = 4'b1000;
        tick();
        i_udf = '0;
        chk("ch3_udf_up_keeps_en", {24'd0, o_tcr[31:24]}, 32'h05);
        i_ovf = 4'b1000;
        tick();
        i_ovf = '0;
        chk("ch3_ovf_up_clears_en", {24'd0, o_tcr[31:24]}, 32'h04);

        i_wren   = 1'b1;
        i_rden   = 1'b1;
        i_addr   = 4'h0;
        i_datain = 8'h39;
        sb.push_back(8'h00);
        tick();
        i_wren   = 1'b0;
        i_rden   = 1'b0;
        i_datain = '0;
        collect("rd_wr_prewrite");
        chk("ch0_load_hi", {28'd0, o_load}, 32'h1);
        rd(4'h0, 8'h31, "rd_ch0_tcr_bit3_masked");
        chk("ch0_load_lo", {28'd0, o_load}, 32'h0);

        wr(4'h3, 8'hFF);
        rd(4'h3, 8'h00, "rd_reserved_ch0");
        wr(4'hF, 8'hFF);
        rd(4'hF, 8'h00, "rd_reserved_ch3");

        i_ovf = 4'b1111;
        i_udf = 4'b1111;
        tick();
        i_ovf = '0;
        i_udf = '0;
        chk("all_ch_tcr", o_tcr, 32'h0404_0631);
`ifdef TIMER_CTRL_BANK_TIE_EN
        chk("all_ch_irq", {28'd0, o_irq}, 32'h4);
`else
        chk("all_ch_irq", {28'd0, o_irq}, 32'hF);
`endif
        rd(4'h1, 8'h03, "rd_ch0_tis_both");
        rd(4'hD, 8'h03, "rd_ch3_tis_both");

        i_rden = 1'b1;
        i_addr = 4'h1;
        tick();
        i_rden = 1'b0;
        i_rst  = 1'b1;
        i_ovf  = 4'b1111;
        #1;
        chk("rst_inflight_rvalid", {31'd0, o_rvalid}, 32'd0);
        tick();
        i_ovf = '0;
        chk("rst2_rvalid",  {31'd0, o_rvalid},  32'd0);
        chk("rst2_dataout", {24'd0, o_dataout}, 32'd0);
        chk("rst2_tcr",     o_tcr,              32'd0);
        chk("rst2_load",    {28'd0, o_load},    32'd0);
        chk("rst2_irq",     {28'd0, o_irq},     32'd0);
        chk("rst2_irq_any", {31'd0, o_irq_any}, 32'd0);
        i_rst = 1'b0;
        tick();
        chk("post_rst_rvalid", {31'd0, o_rvalid}, 32'd0);
        rd(4'h1, 8'h00, "rd_ch0_tis_after_rst");
        rd(4'hA, 8'h00, "rd_ch2_tie_after_rst");
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
